piso_serializer: RTL

Parallel-in, serial-out shifter that takes a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock, with frame delimiters. It is the transmit-side counterpart of the team's flip-flop and shift-register capture chain, and feeds bit-serial DSP datapaths and serial links. Back-to-back words stream with no idle gap.

---
 rtl/serdes_pkg.sv | 7 +
 rtl/bit_counter.sv | 20 ++
 rtl/piso_serializer.sv | 57 +++++
 3 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and counter sizing for the serializer/deserializer pair
package serdes_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/bit_counter.sv
// bit_counter: WIDTH-modulo bit counter with load-to-zero and terminal count
module bit_counter
  import serdes_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == CW'(WIDTH - 1);
  // count up, wrapping after the last bit; clr restarts a new word at zero
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in, gapless framed bit stream out
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic tc, shifting, more, accept;
  assign shifting  = state == ST_SHIFT;
  assign more      = shifting & ~tc;
  assign din_ready = ~shifting | tc;
  assign accept    = din_valid & din_ready;
  assign busy      = sout_valid;
  bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .en (shifting),
    .cnt(cnt),
    .tc (tc)
  );
  // stay in SHIFT while bits remain or a new word arrives on the last bit
  always_comb state_nx = (accept || more) ? ST_SHIFT : ST_IDLE;
  // state register
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nx;
  // shift register and registered serial outputs; sout reads one bit ahead of sr
  always_ff @(posedge clk)
    if (rst) begin
      sr          <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      sr          <= accept ? din : more ? (MSB_FIRST ? sr << 1 : sr >> 1) : sr;
      sout        <= accept ? (MSB_FIRST ? din[WIDTH-1] : din[0])
                   : more ? (MSB_FIRST ? sr[WIDTH-2] : sr[1]) : 1'b0;
      sout_valid  <= accept | more;
      frame_start <= accept;
      frame_end   <= more & (cnt == CW'(WIDTH - 2));
    end
endmodule
